// File: rtl/clk_meas_pkg.sv
// Shared constants and FSM state type for the clock ratio meter.
package clk_meas_pkg;

  localparam int unsigned DefW       = 8;
  localparam int unsigned DefLockCnt = 4;

  function automatic int unsigned timeout_lim(input int unsigned w);
    return 32'd1 << w;
  endfunction

  localparam int unsigned DefTimeoutLim = timeout_lim(DefW);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeasure
  } meas_state_e;

endpackage

// File: rtl/clk_edge_det.sv
// Samples the divided clock in the reference domain and flags its rising edges.
// Optional two-flop synchronizer ahead of the edge register when SYNC_IN_EN is defined.
module clk_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic div_clk_i,
  output logic div_in_o,
  output logic rise_o
);

  logic div_in;
  logic div_d, div_q;

`ifdef SYNC_IN_EN
  logic sync1_d, sync1_q;
  logic sync2_d, sync2_q;

  always_comb begin
    sync1_d = div_clk_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign div_in = sync2_q;
`else
  assign div_in = div_clk_i;
`endif

  always_comb begin
    div_d = div_in;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= 1'b0;
    end else begin
      div_q <= div_d;
    end
  end

  assign div_in_o = div_in;
  assign rise_o   = div_in & ~div_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a divided clock in reference cycles, with lock and timeout.
// Define SYNC_IN_EN to synchronize i_div_clk when it comes from another clock domain.
module clk_ratio_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned W        = DefW,
  parameter int unsigned LOCK_CNT = DefLockCnt
) (
  input  logic         i_ref_clk,
  input  logic         i_rst,
  input  logic         i_meas_en,
  input  logic         i_div_clk,
  output logic [W-1:0] o_period,
  output logic [W-1:0] o_high,
  output logic         o_odd,
  output logic         o_valid,
  output logic         o_locked,
  output logic         o_timeout
);

  localparam logic [W:0] CntLim = (W+1)'(timeout_lim(W));
  localparam logic [W:0] CntOne = (W+1)'(1);
  localparam logic [3:0] LockM  = 4'(LOCK_CNT);

  logic div_in, rise;

  meas_state_e state_d, state_q;
  logic [W:0]   cnt_d, cnt_q;
  logic [W-1:0] hcnt_d, hcnt_q;
  logic [3:0]   m_d, m_q;
  logic [W-1:0] period_d, period_q;
  logic [W-1:0] high_d, high_q;
  logic         valid_d, valid_q;
  logic         locked_d, locked_q;
  logic         timeout_d, timeout_q;

  clk_edge_det u_edge_det (
    .clk_i     (i_ref_clk),
    .rst_i     (i_rst),
    .div_clk_i (i_div_clk),
    .div_in_o  (div_in),
    .rise_o    (rise)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    m_d       = m_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    if (!i_meas_en) begin
      state_d   = StIdle;
      cnt_d     = '0;
      hcnt_d    = '0;
      m_d       = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StArm;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
        StArm, StMeasure: begin
          if (cnt_q == CntLim) begin
            // No edge within the measurable range: restart the hunt for a reference edge.
            state_d   = StArm;
            cnt_d     = '0;
            hcnt_d    = '0;
            m_d       = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
          end else if (rise) begin
            state_d = StMeasure;
            cnt_d   = CntOne;
            hcnt_d  = {{(W-1){1'b0}}, div_in};
            if (state_q == StMeasure) begin
              valid_d   = 1'b1;
              period_d  = cnt_q[W-1:0];
              high_d    = hcnt_q;
              timeout_d = 1'b0;
              // m_q == 0 marks the first measurement since arming.
              if (m_q != 4'd0 && cnt_q[W-1:0] == period_q) begin
                if (m_q < LockM) begin
                  m_d = m_q + 4'd1;
                end
              end else begin
                m_d = 4'd1;
              end
              locked_d = (m_d == LockM);
            end
          end else begin
            cnt_d  = cnt_q + CntOne;
            hcnt_d = hcnt_q + {{(W-1){1'b0}}, div_in};
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      m_q       <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      m_q       <= m_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_period  = period_q;
  assign o_high    = high_q;
  assign o_odd     = period_q[0];
  assign o_valid   = valid_q;
  assign o_locked  = locked_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: timestamp/history model checked every cycle plus literal checks.
module tb_clk_ratio_meter;

  localparam int W       = 8;
  localparam int LockCnt = 4;
  localparam int Limit   = 256;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_meas_en = 1'b0;
  logic         i_div_clk = 1'b0;
  logic [W-1:0] o_period, o_high;
  logic         o_odd, o_valid, o_locked, o_timeout;

  always #5 clk = ~clk;

  clk_ratio_meter #(.W(W), .LOCK_CNT(LockCnt)) dut (
    .i_ref_clk (clk),
    .i_rst     (i_rst),
    .i_meas_en (i_meas_en),
    .i_div_clk (i_div_clk),
    .o_period  (o_period),
    .o_high    (o_high),
    .o_odd     (o_odd),
    .o_valid   (o_valid),
    .o_locked  (o_locked),
    .o_timeout (o_timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", name, got, want, $time);
    end
  endtask

  // Model: per-cycle sample history, timestamps of reference edges, run of equal periods.
  bit           hist [0:8191];
  int           kc = 0;
  bit           model_ok = 1'b0;
  bit           prev_s = 1'b0;
  bit           live = 1'b0;
  int           ref_t = -1;
  int           wait_t = 0;
  int           run = 0;
  int           last_p = 0;
  bit           pipe1 = 1'b0, pipe2 = 1'b0;
  int           e_period = 0, e_high = 0;
  bit           e_valid = 1'b0, e_locked = 1'b0, e_timeout = 1'b0;

  always @(posedge clk) begin
    bit s, r;
    int p, hi;
`ifdef SYNC_IN_EN
    s = pipe2;
    if (i_rst) begin
      pipe2 = 1'b0;
      pipe1 = 1'b0;
    end else begin
      pipe2 = pipe1;
      pipe1 = i_div_clk;
    end
`else
    s = i_div_clk;
`endif
    hist[kc & 8191] = s;
    r = s & ~prev_s;
    e_valid = 1'b0;
    if (i_rst) begin
      e_period = 0; e_high = 0; e_locked = 0; e_timeout = 0; live = 0; run = 0;
    end else if (!i_meas_en) begin
      e_locked = 0; e_timeout = 0; live = 0; run = 0;
    end else if (!live) begin
      live = 1; ref_t = -1; wait_t = kc + 1; run = 0;
    end else if ((ref_t >= 0) ? (kc - ref_t >= Limit) : (kc - wait_t >= Limit)) begin
      e_timeout = 1; e_locked = 0; run = 0; ref_t = -1; wait_t = kc + 1;
    end else if (r) begin
      if (ref_t >= 0) begin
        p = kc - ref_t;
        hi = 0;
        for (int t = ref_t; t < kc; t++) hi += int'(hist[t & 8191]);
        e_valid = 1; e_period = p; e_high = hi; e_timeout = 0;
        run = (run > 0 && p == last_p) ? run + 1 : 1;
        last_p = p;
        e_locked = (run >= LockCnt);
      end
      ref_t = kc;
    end
    prev_s = i_rst ? 1'b0 : s;
    kc++;
    model_ok = 1'b1;
  end

  int vcount = 0;
  int last_valid_cyc = 0;
  int to_cyc = 0;
  bit to_prev = 1'b0;

  always @(negedge clk) begin
    if (model_ok) begin
      chk("valid", int'(o_valid), int'(e_valid));
      chk("period", int'(o_period), e_period);
      chk("high", int'(o_high), e_high);
      chk("odd", int'(o_odd), e_period % 2);
      chk("locked", int'(o_locked), int'(e_locked));
      chk("timeout", int'(o_timeout), int'(e_timeout));
    end
    if (o_valid === 1'b1) begin
      vcount++;
      last_valid_cyc = kc;
    end
    if (o_timeout === 1'b1 && !to_prev) to_cyc = kc;
    to_prev = (o_timeout === 1'b1);
  end

  task automatic drive(input bit d, input bit e, input bit r);
    i_div_clk = d;
    i_meas_en = e;
    i_rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input int ratio, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < ratio; c++) drive(c < hi, 1'b1, 1'b0);
  endtask

  // After an abort: one rising edge must not produce o_valid, the second must.
  task automatic reenable_check(input string tag);
    int v0;
    bit seen;
    v0 = vcount;
    drive(0, 1, 0);
    drive(0, 1, 0);
    run_div(4, 2, 1);
    chk({tag, "_no_valid_first_edge"}, vcount, v0);
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      drive((i % 4) < 2, 1, 0);
      seen = (vcount != v0);
    end
    chk({tag, "_valid_after_second_edge"}, vcount, v0 + 1);
    chk({tag, "_period"}, int'(o_period), 4);
  endtask

  initial begin
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);
    chk("rst_period", int'(o_period), 0);
    chk("rst_high", int'(o_high), 0);
    chk("rst_odd", int'(o_odd), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_locked", int'(o_locked), 0);
    chk("rst_timeout", int'(o_timeout), 0);
    drive(0, 0, 0);

    // Ratio 4, 50% duty
    run_div(4, 2, 10);
    chk("r4_period", int'(o_period), 4);
    chk("r4_high", int'(o_high), 2);
    chk("r4_odd", int'(o_odd), 0);
    chk("r4_locked", int'(o_locked), 1);
    chk("r4_vcount", vcount, 8);

    // Ratio 5
    run_div(5, 2, 10);
    chk("r5_period", int'(o_period), 5);
    chk("r5_high", int'(o_high), 2);
    chk("r5_odd", int'(o_odd), 1);
    chk("r5_locked", int'(o_locked), 1);

    // Switch to 6: lock drops on the first period of 6, returns on the fourth
    run_div(6, 3, 2);
    chk("r6_period", int'(o_period), 6);
    chk("r6_unlocked", int'(o_locked), 0);
    run_div(6, 3, 3);
    chk("r6_relocked", int'(o_locked), 1);

    // Divider stops
    for (int i = 0; i < 400 && o_timeout !== 1'b1; i++) drive(0, 1, 0);
    drive(0, 1, 0);
    chk("stall_timeout", int'(o_timeout), 1);
    chk("stall_delay", to_cyc - last_valid_cyc, 256);
    chk("stall_unlocked", int'(o_locked), 0);
    run_div(3, 1, 4);
    chk("r3_timeout_clear", int'(o_timeout), 0);
    chk("r3_period", int'(o_period), 3);
    chk("r3_high", int'(o_high), 1);
    chk("r3_odd", int'(o_odd), 1);

    // Largest measurable ratio
    run_div(255, 128, 3);
    chk("r255_period", int'(o_period), 255);
    chk("r255_high", int'(o_high), 128);
    chk("r255_timeout", int'(o_timeout), 0);

    // Reset mid-period
    run_div(4, 2, 6);
    chk("pre_rst_locked", int'(o_locked), 1);
    drive(1, 1, 0);
    drive(1, 1, 1);
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_locked", int'(o_locked), 0);
    chk("midrst_timeout", int'(o_timeout), 0);
    chk("midrst_period", int'(o_period), 0);
    reenable_check("rst");

    // Enable dropped mid-period: flags clear, measured values hold
    run_div(4, 2, 6);
    chk("pre_dis_locked", int'(o_locked), 1);
    drive(1, 1, 0);
    drive(1, 0, 0);
    chk("dis_valid", int'(o_valid), 0);
    chk("dis_locked", int'(o_locked), 0);
    chk("dis_timeout", int'(o_timeout), 0);
    chk("dis_period_hold", int'(o_period), 4);
    chk("dis_high_hold", int'(o_high), 2);
    reenable_check("en");

    drive(0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
